// File: rtl/dct_pkg.sv
// Purpose : shared constants and state type for the 4x4 DCT transpose buffer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package dct_pkg;

    localparam int COEF_W    = 22;
    localparam int DCT_N     = 4;
    localparam int BLK_WORDS = 16;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Column-major output index j maps to row-major storage address
    // row = j%4, col = j/4  ->  addr = row*4 + col.
    function automatic logic [3:0] tp_addr(input logic [3:0] j);
        return {j[1:0], j[3:2]};
    endfunction

endpackage

// File: rtl/dct_tp_mem.sv
// Purpose : register array holding one 4x4 coefficient block.
// Latency : write lands on the clock edge; read is combinational.
// Backpressure: none, the caller owns write enable and read address.
// Ports   : clk, wr_en/wr_addr/wr_data write port, rd_addr/rd_data async read.
module dct_tp_mem
    import dct_pkg::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int DEPTH  = BLK_WORDS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are deliberately not reset; a block is always fully
    // rewritten before it is drained.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dct_transpose_4x4.sv
// Purpose : buffers 16 row-major coefficients from a FIFO, replays them column-major.
// Latency : first output valid 2 cycles after the 16th fifo_rd_en; 1 word/handshake.
// Backpressure: out_ready=0 holds the presented word; FIFO reads stop while draining.
// Ports   : clk, rst (async, active low), fifo_empty/fifo_rd_en/fifo_dout upstream,
//           out_data/out_valid/out_ready/out_last/out_eob downstream, busy (DRAIN).
// Option  : DCT_TRANSPOSE_STATS_EN adds blk_cnt, a 16-bit wrapping completed-block count.
module dct_transpose_4x4
    import dct_pkg::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int N      = DCT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_eob,
`ifdef DCT_TRANSPOSE_STATS_EN
    output logic [15:0]       blk_cnt,
`endif
    output logic              busy
);

    localparam logic [4:0] WORDS = 5'(N * N);

    state_t            state;
    logic [4:0]        req_cnt;   // reads issued in this block
    logic [3:0]        cap_cnt;   // words captured in this block
    logic [3:0]        j;         // drain index
    logic              rd_pend;   // FIFO word arrives this cycle
    logic [DATA_W-1:0] rd_data;
    logic              drain_hs;
    logic              last_hs;

    // rst gates the strobe directly so it is low for the whole reset pulse,
    // not just after the state has been forced.
    assign fifo_rd_en = rst && (state == FILL) && !fifo_empty && (req_cnt < WORDS);

    assign drain_hs = (state == DRAIN) && out_ready;
    assign last_hs  = drain_hs && (j == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FILL;
            req_cnt <= '0;
            cap_cnt <= '0;
            j       <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            case (state)
                FILL: begin
                    if (fifo_rd_en) begin
                        req_cnt <= req_cnt + 5'd1;
                    end
                    if (rd_pend) begin
                        cap_cnt <= cap_cnt + 4'd1;
                        // The 16th word lands in memory on this edge, so
                        // the async read path is valid in the DRAIN cycle.
                        if (cap_cnt == 4'd15) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state   <= FILL;
                        req_cnt <= '0;
                        cap_cnt <= '0;
                        j       <= '0;
                    end else if (drain_hs) begin
                        j <= j + 4'd1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef DCT_TRANSPOSE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
        end else if (last_hs) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

    dct_tp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (BLK_WORDS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (rd_pend && (state == FILL)),
        .wr_addr (cap_cnt),
        .wr_data (fifo_dout),
        .rd_addr (tp_addr(j)),
        .rd_data (rd_data)
    );

    // Outputs are decoded from registered state and index only, so they
    // cannot change while out_ready is low.
    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign out_data  = out_valid ? rd_data : '0;
    assign out_last  = out_valid && (j[1:0] == 2'd3);
    assign out_eob   = out_valid && (j == 4'd15);

endmodule

// File: tb/tb_dct_transpose_4x4.sv
// Purpose : self-checking bench for dct_transpose_4x4 against a queue-based transpose model.
// Latency : n/a.
// Backpressure: bench drives out_ready stalls and fifo_empty gaps.
module tb_dct_transpose_4x4;

    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          out_eob;
    logic          busy;
`ifdef DCT_TRANSPOSE_STATS_EN
    logic [15:0]   blk_cnt;
    int            blk_model = 0;
`endif

    always #5 clk = ~clk;

    dct_transpose_4x4 #(.DATA_W(DW), .N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_eob    (out_eob),
`ifdef DCT_TRANSPOSE_STATS_EN
        .blk_cnt    (blk_cnt),
`endif
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int src[$];        // words waiting in the upstream FIFO
    int delivered[$];  // words handed to the DUT in the current block
    int obs[$];        // words accepted downstream
    int lastw[$];
    int eobw[$];
    int out_idx = 0, age = 0, blocks = 0;
    int stall_left = 0, nready_left = 0, hold_seen = 0;
    int rd_total = 0, rd_in_drain = 0, rd_word = 0;
    bit stall_arm = 0, hold_arm = 0, rd_taken = 0, force_on = 0;

    int exp_tp[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Upstream FIFO and downstream sink, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rd_taken) begin
            fifo_dout = DW'(rd_word);
            rd_taken  = 0;
        end else begin
            fifo_dout = 22'h2AAAAA;
        end
        fifo_empty = (stall_left > 0) || (src.size() == 0);
        if (stall_left > 0) stall_left--;
        if (hold_arm && out_idx == 1 && out_valid) begin
            nready_left = 3;
            hold_arm    = 0;
        end
        out_ready = (nready_left == 0);
        if (nready_left > 0) nready_left--;
    end

    // Model and per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        bit exp_v;
        bit exp_rd;
        int a;
        if (!rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_last", out_last, 0);
            check("rst_eob", out_eob, 0);
            check("rst_busy", busy, 0);
            check("rst_data", out_data, 0);
            delivered.delete();
            out_idx  = 0;
            age      = 0;
            rd_taken = 0;
`ifdef DCT_TRANSPOSE_STATS_EN
            blk_model = 0;
            check("rst_blk_cnt", blk_cnt, 0);
`endif
        end else begin
            exp_v  = (delivered.size() == 16) && (age >= 1);
            exp_rd = !fifo_empty && (delivered.size() < 16);
            a      = (out_idx % 4) * 4 + out_idx / 4;
            check("rd_en", fifo_rd_en, exp_rd);
            check("valid", out_valid, exp_v);
            check("busy", busy, exp_v);
            if (exp_v) begin
                check("data", out_data, delivered[a]);
                check("last", out_last, (out_idx % 4) == 3);
                check("eob", out_eob, out_idx == 15);
            end else begin
                check("last_idle", out_last, 0);
                check("eob_idle", out_eob, 0);
            end
`ifdef DCT_TRANSPOSE_STATS_EN
            if (!force_on) check("blk_cnt", blk_cnt, blk_model % 65536);
`endif
            if (out_valid && !out_ready && out_data == DW'(4)) hold_seen++;
            if (fifo_rd_en && out_valid) rd_in_drain++;

            if (exp_v && out_ready) begin
                obs.push_back(delivered[a]);
                if (out_last) lastw.push_back(int'(out_data));
                if (out_eob) eobw.push_back(int'(out_data));
                out_idx++;
                if (out_idx == 16) begin
                    delivered.delete();
                    out_idx = 0;
                    age     = 0;
                    blocks++;
`ifdef DCT_TRANSPOSE_STATS_EN
                    blk_model = (blk_model + 1) % 65536;
`endif
                end
            end else if (delivered.size() == 16) begin
                age++;
            end

            if (fifo_rd_en && delivered.size() < 16 && src.size() > 0) begin
                rd_word = src.pop_front();
                delivered.push_back(rd_word);
                rd_taken = 1;
                rd_total++;
                if (delivered.size() == 16) age = 0;
                if (stall_arm && delivered.size() == 7) begin
                    stall_left = 5;
                    stall_arm  = 0;
                end
            end
        end
    end

    task automatic push_block(input int base);
        for (int i = 0; i < 16; i++) src.push_back(base + i);
    endtask

    task automatic wait_blocks(input int target, input string name);
        int n = 0;
        while (blocks < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        check(name, blocks >= target, 1);
    endtask

    task automatic check_order(input string name);
        check({name, "_count"}, obs.size(), 16);
        for (int i = 0; i < 16; i++) check(name, obs[i], exp_tp[i]);
    endtask

    initial begin
        int n;
        int rd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Plain block 0..15.
        obs.delete(); lastw.delete(); eobw.delete();
        push_block(0);
        wait_blocks(1, "s1_done");
        check_order("s1_order");
        check("s1_last_n", lastw.size(), 4);
        for (int i = 0; i < 4; i++) check("s1_last_word", lastw[i], 12 + i);
        check("s1_eob_n", eobw.size(), 1);
        check("s1_eob_word", eobw[0], 15);

        // FIFO empty for 5 cycles after the 7th read.
        repeat (3) @(posedge clk);
        obs.delete();
        rd0 = rd_total;
        stall_arm = 1;
        push_block(0);
        wait_blocks(2, "s2_done");
        check_order("s2_order");
        check("s2_reads", rd_total - rd0, 16);

        // Downstream holds word 4 for 3 cycles.
        repeat (3) @(posedge clk);
        obs.delete();
        hold_seen = 0;
        hold_arm  = 1;
        push_block(0);
        wait_blocks(3, "s3_done");
        check("s3_hold_cycles", hold_seen, 3);
        check("s3_word1", obs[1], 4);
        check("s3_word2", obs[2], 8);
        check_order("s3_order");

        // Back-to-back blocks.
        repeat (3) @(posedge clk);
        obs.delete();
        rd_in_drain = 0;
        push_block(0);
        push_block(100);
        wait_blocks(5, "s4_done");
        check("s4_count", obs.size(), 32);
        check("s4_second_0", obs[16], 100);
        check("s4_second_1", obs[17], 104);
        check("s4_rd_in_drain", rd_in_drain, 0);

        // Reset after 9 captures, then a fresh block.
        for (int i = 0; i < 9; i++) src.push_back(50 + i);
        n = 0;
        while (delivered.size() < 9 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("s5_nine_read", delivered.size(), 9);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        src.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        obs.delete();
        push_block(200);
        wait_blocks(6, "s5_done");
        check("s5_first_0", obs[0], 200);
        check("s5_first_1", obs[1], 204);

`ifdef DCT_TRANSPOSE_STATS_EN
        push_block(0);
        push_block(16);
        wait_blocks(8, "s6_done");
        repeat (2) @(posedge clk);
        check("s6_blk_cnt_3", blk_cnt, 3);
        @(posedge clk);
        #1;
        force_on = 1;
        force dut.blk_cnt = 16'hFFFE;
        blk_model = 65534;
        @(posedge clk);
        #1;
        release dut.blk_cnt;
        @(posedge clk);
        #1;
        force_on = 0;
        push_block(0);
        push_block(16);
        wait_blocks(10, "s7_done");
        repeat (2) @(posedge clk);
        check("s7_blk_cnt_wrap", blk_cnt, 0);
`endif

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks passed, expected finish", n_pass);
        $fatal(1, "watchdog");
    end

endmodule
